// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, the "no register"
// ID and the constants that make up a pipeline NOP bubble.
package y86_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  // Bubble contents: a NOP with no register traffic and a good status.
  localparam logic [3:0] BUBBLE_ICODE = INOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
  localparam logic [2:0] BUBBLE_STAT  = SAOK;
  localparam logic [3:0] BUBBLE_RID   = RNONE;
  localparam logic       BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field flop: synchronous reset and bubble both load
// BUBBLE_VAL, stall holds, otherwise the input is captured.
module pipe_field_reg #(
  parameter int            W          = 1,
  parameter logic [W-1:0]  BUBBLE_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field register with priority reset > stall > bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= BUBBLE_VAL;
    end else if (stall) begin
      q <= q;
    end else if (bubble) begin
      q <= BUBBLE_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/e_pipe_reg.sv
// Decode-to-execute pipeline register for the 5-stage Y86-64 core.
// One pipe_field_reg per field; stall holds, bubble inserts a NOP, and a
// sticky ctrl_err flags stall and bubble asserted together (stall wins).
// Optional macro E_PIPE_REG_PERF_EN adds load/stall/bubble perf counters.
module e_pipe_reg
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RID_W  = 4,
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [STAT_W-1:0] D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [DATA_W-1:0] d_valA,
  input  logic [DATA_W-1:0] d_valB,
  input  logic [RID_W-1:0]  d_rA,
  input  logic [RID_W-1:0]  d_rB,
  input  logic [RID_W-1:0]  d_dstE,
  input  logic [RID_W-1:0]  d_dstM,
  input  logic [RID_W-1:0]  d_srcA,
  input  logic [RID_W-1:0]  d_srcB,
  output logic [STAT_W-1:0] E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [DATA_W-1:0] E_valP,
  output logic [RID_W-1:0]  E_rA,
  output logic [RID_W-1:0]  E_rB,
  output logic [RID_W-1:0]  E_dstE,
  output logic [RID_W-1:0]  E_dstM,
  output logic [RID_W-1:0]  E_srcA,
  output logic [RID_W-1:0]  E_srcB,
  output logic              E_valid,
  output logic              ctrl_err
`ifdef E_PIPE_REG_PERF_EN
  ,
  output logic [DATA_W-1:0] perf_loads,
  output logic [DATA_W-1:0] perf_stalls,
  output logic [DATA_W-1:0] perf_bubbles
`endif
);

  localparam logic [STAT_W-1:0] STAT_BUB = STAT_W'(BUBBLE_STAT);
  localparam logic [RID_W-1:0]  RID_BUB  = RID_W'(BUBBLE_RID);
  localparam logic [DATA_W-1:0] DATA_BUB = {DATA_W{1'b0}};

  logic conflict_s;
  assign conflict_s = E_stall & E_bubble;

  pipe_field_reg #(.W(STAT_W), .BUBBLE_VAL(STAT_BUB)) u_stat (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(D_stat), .q(E_stat));
  pipe_field_reg #(.W(4), .BUBBLE_VAL(BUBBLE_ICODE)) u_icode (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(D_icode), .q(E_icode));
  pipe_field_reg #(.W(4), .BUBBLE_VAL(BUBBLE_IFUN)) u_ifun (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(D_ifun), .q(E_ifun));
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL(DATA_BUB)) u_valc (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(D_valC), .q(E_valC));
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL(DATA_BUB)) u_vala (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_valA), .q(E_valA));
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL(DATA_BUB)) u_valb (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_valB), .q(E_valB));
  pipe_field_reg #(.W(DATA_W), .BUBBLE_VAL(DATA_BUB)) u_valp (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(D_valP), .q(E_valP));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_ra (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_rA), .q(E_rA));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_rb (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_rB), .q(E_rB));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_dste (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_dstE), .q(E_dstE));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_dstm (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_dstM), .q(E_dstM));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_srca (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_srcA), .q(E_srcA));
  pipe_field_reg #(.W(RID_W), .BUBBLE_VAL(RID_BUB)) u_srcb (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(d_srcB), .q(E_srcB));

  // Valid marker: every load is a real instruction, a bubble is not.
  pipe_field_reg #(.W(1), .BUBBLE_VAL(BUBBLE_VALID)) u_valid (
    .clk(clk), .reset(reset), .stall(E_stall), .bubble(E_bubble), .d(1'b1), .q(E_valid));

  // Sticky control-error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_err <= 1'b0;
    end else if (conflict_s) begin
      ctrl_err <= 1'b1;
    end else begin
      ctrl_err <= ctrl_err;
    end
  end

`ifdef E_PIPE_REG_PERF_EN
  logic load_s;
  assign load_s = ~E_stall & ~E_bubble;

  // Perf counters, wrapping naturally at 2^DATA_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads   <= {DATA_W{1'b0}};
      perf_stalls  <= {DATA_W{1'b0}};
      perf_bubbles <= {DATA_W{1'b0}};
    end else if (E_stall) begin
      perf_stalls  <= perf_stalls + DATA_W'(1);
    end else if (E_bubble) begin
      perf_bubbles <= perf_bubbles + DATA_W'(1);
    end else if (load_s && (D_icode != INOP)) begin
      perf_loads   <= perf_loads + DATA_W'(1);
    end else begin
      perf_loads   <= perf_loads;
    end
  end
`endif

endmodule

// File: tb/tb_e_pipe_reg.sv
// Self-checking bench for e_pipe_reg: a behavioural model pushes the expected
// E-stage bundle per edge into a queue, which is popped and compared after it.
module tb_e_pipe_reg;

`ifdef E_PIPE_REG_PERF_EN
  localparam int DW = 8;
`else
  localparam int DW = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          E_stall = 1'b0;
  logic          E_bubble = 1'b0;
  logic [2:0]    D_stat = 3'd1;
  logic [3:0]    D_icode = 4'h1;
  logic [3:0]    D_ifun = 4'h0;
  logic [DW-1:0] D_valC = '0, D_valP = '0, d_valA = '0, d_valB = '0;
  logic [3:0]    d_rA = 4'h0, d_rB = 4'h0, d_dstE = 4'h0, d_dstM = 4'h0, d_srcA = 4'h0, d_srcB = 4'h0;
  logic [2:0]    E_stat;
  logic [3:0]    E_icode, E_ifun;
  logic [DW-1:0] E_valC, E_valA, E_valB, E_valP;
  logic [3:0]    E_rA, E_rB, E_dstE, E_dstM, E_srcA, E_srcB;
  logic          E_valid, ctrl_err;
`ifdef E_PIPE_REG_PERF_EN
  logic [DW-1:0] perf_loads, perf_stalls, perf_bubbles;
`endif

  e_pipe_reg #(.DATA_W(DW), .RID_W(4), .STAT_W(3)) dut (
    .clk(clk), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_valC(D_valC), .D_valP(D_valP), .d_valA(d_valA), .d_valB(d_valB),
    .d_rA(d_rA), .d_rB(d_rB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_valP(E_valP),
    .E_rA(E_rA), .E_rB(E_rB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valid(E_valid), .ctrl_err(ctrl_err)
`ifdef E_PIPE_REG_PERF_EN
    , .perf_loads(perf_loads), .perf_stalls(perf_stalls), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    stat;
    logic [3:0]    icode, ifun;
    logic [DW-1:0] valc, vala, valb, valp;
    logic [3:0]    ra, rb, dste, dstm, srca, srcb;
    logic          valid, err;
    logic [DW-1:0] ploads, pstalls, pbubbles;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_bubble_model();
    m.stat = 3'd1; m.icode = 4'h1; m.ifun = 4'h0;
    m.valc = '0; m.vala = '0; m.valb = '0; m.valp = '0;
    m.ra = 4'hF; m.rb = 4'hF; m.dste = 4'hF; m.dstm = 4'hF; m.srca = 4'hF; m.srcb = 4'hF;
    m.valid = 1'b0;
  endtask

  // Behavioural next-state of the register for one edge.
  task automatic model_step(input logic rst, input logic stl, input logic bub);
    if (rst) begin
      set_bubble_model();
      m.err = 1'b0; m.ploads = '0; m.pstalls = '0; m.pbubbles = '0;
    end else if (stl) begin
      if (bub) m.err = 1'b1;
      m.pstalls = m.pstalls + 1'b1;
    end else if (bub) begin
      set_bubble_model();
      m.pbubbles = m.pbubbles + 1'b1;
    end else begin
      m.stat = D_stat; m.icode = D_icode; m.ifun = D_ifun;
      m.valc = D_valC; m.vala = d_valA; m.valb = d_valB; m.valp = D_valP;
      m.ra = d_rA; m.rb = d_rB; m.dste = d_dstE; m.dstm = d_dstM;
      m.srca = d_srcA; m.srcb = d_srcB; m.valid = 1'b1;
      if (D_icode != 4'h1) m.ploads = m.ploads + 1'b1;
    end
    exp_q.push_back(m);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("stat",  64'(E_stat),  64'(e.stat));
      check_eq("icode", 64'(E_icode), 64'(e.icode));
      check_eq("ifun",  64'(E_ifun),  64'(e.ifun));
      check_eq("valC",  64'(E_valC),  64'(e.valc));
      check_eq("valA",  64'(E_valA),  64'(e.vala));
      check_eq("valB",  64'(E_valB),  64'(e.valb));
      check_eq("valP",  64'(E_valP),  64'(e.valp));
      check_eq("rA",    64'(E_rA),    64'(e.ra));
      check_eq("rB",    64'(E_rB),    64'(e.rb));
      check_eq("dstE",  64'(E_dstE),  64'(e.dste));
      check_eq("dstM",  64'(E_dstM),  64'(e.dstm));
      check_eq("srcA",  64'(E_srcA),  64'(e.srca));
      check_eq("srcB",  64'(E_srcB),  64'(e.srcb));
      check_eq("valid", 64'(E_valid), 64'(e.valid));
      check_eq("ctrl_err", 64'(ctrl_err), 64'(e.err));
`ifdef E_PIPE_REG_PERF_EN
      check_eq("perf_loads",   64'(perf_loads),   64'(e.ploads));
      check_eq("perf_stalls",  64'(perf_stalls),  64'(e.pstalls));
      check_eq("perf_bubbles", 64'(perf_bubbles), 64'(e.pbubbles));
`endif
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic bub);
    reset = rst; E_stall = stl; E_bubble = bub;
    model_step(rst, stl, bub);
    @(posedge clk);
    #1;
    compare_out();
    reset = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
  endtask

  task automatic rand_d();
    D_stat = 3'($urandom_range(1, 4));
    D_icode = 4'($urandom); D_ifun = 4'($urandom);
    D_valC = DW'({$urandom, $urandom}); D_valP = DW'({$urandom, $urandom});
    d_valA = DW'({$urandom, $urandom}); d_valB = DW'({$urandom, $urandom});
    d_rA = 4'($urandom); d_rB = 4'($urandom); d_dstE = 4'($urandom);
    d_dstM = 4'($urandom); d_srcA = 4'($urandom); d_srcB = 4'($urandom);
  endtask

  initial begin
    logic [63:0] c100;
    int r;
    c100 = 64'h100;
    m = '{default: '0};

    // Reset for two edges with random decode inputs.
    rand_d(); step(1'b1, 1'b0, 1'b0);
    rand_d(); step(1'b1, 1'b0, 1'b0);
    check_eq("rst_icode", 64'(E_icode), 64'h1);
    check_eq("rst_ifun",  64'(E_ifun),  64'h0);
    check_eq("rst_rA",    64'(E_rA),    64'hF);
    check_eq("rst_srcB",  64'(E_srcB),  64'hF);
    check_eq("rst_valC",  64'(E_valC),  64'h0);
    check_eq("rst_stat",  64'(E_stat),  64'h1);
    check_eq("rst_valid", 64'(E_valid), 64'h0);
    check_eq("rst_err",   64'(ctrl_err), 64'h0);

    // Plain load of an OPq.
    rand_d(); D_icode = 4'h6; D_ifun = 4'h0; d_valA = DW'(64'h5); d_valB = DW'(64'hA); d_dstE = 4'h3;
    step(1'b0, 1'b0, 1'b0);
    check_eq("ld_valA",  64'(E_valA),  64'h5);
    check_eq("ld_valB",  64'(E_valB),  64'hA);
    check_eq("ld_dstE",  64'(E_dstE),  64'h3);
    check_eq("ld_valid", 64'(E_valid), 64'h1);

    // Load irmovq then hold it through three stalled cycles.
    step(1'b1, 1'b0, 1'b0);
    rand_d(); D_icode = 4'h3; D_valC = DW'(c100);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step(1'b0, 1'b1, 1'b0);
      check_eq("stall_icode", 64'(E_icode), 64'h3);
      check_eq("stall_valC",  64'(E_valC),  64'(DW'(c100)));
    end
`ifdef E_PIPE_REG_PERF_EN
    check_eq("perf_stalls3", 64'(perf_stalls), 64'd3);
`endif

    // Reset asserted mid-stall clears the held contents.
    rand_d(); step(1'b1, 1'b1, 1'b0);
    check_eq("rst_in_stall", 64'(E_icode), 64'h1);

    // Load, bubble, load: 5, NOP, 2.
    rand_d(); D_icode = 4'h5; step(1'b0, 1'b0, 1'b0);
    check_eq("seq_5", 64'(E_icode), 64'h5);
    rand_d(); step(1'b0, 1'b0, 1'b1);
    check_eq("seq_nop",   64'(E_icode), 64'h1);
    check_eq("seq_nop_v", 64'(E_valid), 64'h0);
    check_eq("seq_nop_r", 64'(E_rB),    64'hF);
    rand_d(); D_icode = 4'h2; step(1'b0, 1'b0, 1'b0);
    check_eq("seq_2",   64'(E_icode), 64'h2);
    check_eq("seq_2_v", 64'(E_valid), 64'h1);

    // Stall and bubble together: hold, sticky error, cleared by reset.
    rand_d(); step(1'b0, 1'b1, 1'b1);
    check_eq("conf_hold", 64'(E_icode), 64'h2);
    check_eq("conf_err",  64'(ctrl_err), 64'h1);
    for (int i = 0; i < 10; i++) begin
      rand_d(); step(1'b0, 1'b0, 1'b0);
      check_eq("conf_sticky", 64'(ctrl_err), 64'h1);
    end
    rand_d(); step(1'b1, 1'b0, 1'b0);
    check_eq("conf_clear", 64'(ctrl_err), 64'h0);

    // Random control mix.
    for (int i = 0; i < 200; i++) begin
      rand_d();
      r = int'($urandom_range(0, 15));
      step(r == 0, (r >= 1) && (r <= 3), (r >= 3) && (r <= 5));
    end

`ifdef E_PIPE_REG_PERF_EN
    // 257 non-NOP loads wrap an 8-bit counter to 1.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      rand_d(); D_icode = 4'h6;
      step(1'b0, 1'b0, 1'b0);
    end
    check_eq("perf_wrap", 64'(perf_loads), 64'd1);
`endif

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e_pipe_reg.md
# e_pipe_reg

Parametrised decode-to-execute pipeline register for the 5-stage Y86-64 core. It captures the decode-stage bundle on each rising edge of `clk`. Pipeline control can hold the contents with a stall or replace them with a NOP bubble. It also raises a sticky flag on illegal control combinations. It sits between decode/register-read and the ALU stage and feeds the execute-stage forwarding sources.

## Interface
- `DATA_W`, 64, width of valC/valA/valB/valP
- `RID_W`, 4, register-ID width (rA, rB, dstE, dstM, srcA, srcB)
- `STAT_W`, 3, status width
- `clk` in 1: rising-edge clock, the only clock
- `reset` in 1: synchronous, active-high; sampled on `posedge clk`
- `E_stall` in 1: hold current contents
- `E_bubble` in 1: load a NOP bubble
- `D_stat` in STAT_W; `D_icode` in 4; `D_ifun` in 4: decode bundle
- `D_valC`, `D_valP`, `d_valA`, `d_valB` in DATA_W each: decode bundle
- `d_rA`, `d_rB`, `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB` in RID_W each: decode bundle
- `E_*` out: registered copy of every input field, same width (`E_stat`, `E_icode`, `E_ifun`, `E_valC`, `E_valA`, `E_valB`, `E_valP`, `E_rA`, `E_rB`, `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`)
- `E_valid` out 1: 1 when the contents are a real instruction, 0 when they are a bubble
- `ctrl_err` out 1: sticky; set on simultaneous stall and bubble

## Operation
- Bubble value: stat=SAOK(1), icode=INOP(1), ifun=0, all data fields 0, all register IDs RNONE(4'hF), `E_valid`=0.
- Each edge uses this priority: `reset` > `E_stall` > `E_bubble` > load.
  - reset: bubble value is loaded; `ctrl_err`=0; perf counters=0.
  - stall: all `E_*` and `E_valid` hold.
  - bubble: bubble value is loaded.
  - load: every `E_*` takes its `D_*`/`d_*` source; `E_valid`=1.
- `E_stall`&&`E_bubble` in the same cycle: stall wins and `ctrl_err` is set. It stays set until `reset`.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: a value presented before edge N appears after edge N.
- The reset value of every output equals the bubble value; `E_valid`=0, `ctrl_err`=0.
- Reset has effect only at an edge. Asserting it mid-stall clears the held contents at that edge.
- A stall of any length keeps the outputs bit-identical for every stalled cycle.
- A bubble and a load in consecutive cycles produce a one-cycle NOP followed by the loaded bundle.

## Configuration
- `E_PIPE_REG_PERF_EN` defined adds three counters as outputs, all `DATA_W` wide, all cleared by reset, all wrapping modulo 2^DATA_W:
  - `perf_loads`: increments on each load with `D_icode`≠INOP.
  - `perf_stalls`: increments on each stalled cycle.
  - `perf_bubbles`: increments on each bubble that wins priority.
- `E_PIPE_REG_PERF_EN` undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared `y86_pkg` holds:
  - icode constants (INOP etc.)
  - stat codes SAOK=1, SHLT=2, SADR=3, SINS=4
  - RNONE
  - the bubble-value constants
- `D_icode`/`D_ifun` stay fixed at 4 bits because ISA encoding is fixed; all other widths follow the parameters.
- Natural sub-module: `pipe_field_reg`, a generic width-parameterised flop with reset, stall and bubble (bubble value as a parameter). It is instantiated once per field, so the stage becomes a thin aggregation.
- The perf counters live inline under the macro.

## Test plan
- Reset: hold `reset`=1 for 2 edges with random D inputs -> icode=1, ifun=0, all RIDs=4'hF, data fields=0, stat=1, `E_valid`=0, `ctrl_err`=0.
- Load: `D_icode`=6, `D_ifun`=0, `d_valA`=64'h5, `d_valB`=64'hA, `d_dstE`=3 -> next cycle `E_valA`=5, `E_valB`=A, `E_dstE`=3, `E_valid`=1.
- Stall: load icode=3 (irmovq), `D_valC`=64'h100; then 3 cycles of `E_stall`=1 with changing inputs -> outputs stay at icode=3, valC=0x100 throughout; `perf_stalls`=3 when macro defined.
- Bubble: load icode=5, then `E_bubble`=1 for one cycle, then load icode=2 -> E sequence is 5, 1 (`E_valid`=0, RIDs=F), 2.
- Conflict: `E_stall`=`E_bubble`=1 for one cycle -> outputs hold; `ctrl_err`=1 stays set for 10 further cycles; a `reset` pulse clears it.
- Counter wrap: with macro defined and `DATA_W`=8, issue 257 non-NOP loads -> `perf_loads`=1.
